// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle LEGv8 control sequencer.
// Runs FETCH -> DECODE -> EXEC0 -> [EXEC1] -> FETCH. It selects the class decoder
// control word, stalls on data memory, and flags illegal opcodes.
// Optional feature macro: ILLEGAL_TRAP_EN. When it is defined, an illegal opcode parks
// the sequencer in a sticky TRAP state. When it is undefined, the illegal opcode is
// retired as a NOP.
module control_sequencer #(
    parameter int unsigned CW_W   = 94,
    parameter int unsigned NS_BIT = 0,
    parameter int unsigned MW_BIT = 1,
    parameter int unsigned RW_BIT = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [31:0]     instr_in,
    input  logic            instr_valid,
    input  logic            mem_ready,
    input  logic [CW_W-1:0] cw_logic,
    input  logic [CW_W-1:0] cw_arith,
    input  logic [CW_W-1:0] cw_move,
    input  logic [CW_W-1:0] cw_mem,
    input  logic [CW_W-1:0] cw_branch,
    output logic            fetch_req,
    output logic [31:0]     ir,
    output logic            state,
    output logic [CW_W-1:0] cw_out,
    output logic            illegal
);

`ifdef ILLEGAL_TRAP_EN
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC0, S_EXEC1, S_TRAP} fsm_t;
`else
    typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC0, S_EXEC1} fsm_t;
`endif

    typedef enum logic [2:0] {
        CLS_NONE, CLS_LOGIC, CLS_ARITH, CLS_MOVE, CLS_MEM, CLS_BRANCH, CLS_ILLEGAL
    } cls_t;

    fsm_t            fsm_q, fsm_d;
    cls_t            cls_q, cls_d, dec_cls;
    logic [31:0]     ir_d;
    logic [CW_W-1:0] sel_cw;
    logic            stall;

    // Opcode group classification of the held instruction; the first match wins.
    always_comb begin
        dec_cls = CLS_ILLEGAL;
        if (ir[28:26] == 3'b100 && ir[25:23] == 3'b100) begin
            dec_cls = CLS_LOGIC;
        end else if (ir[28:26] == 3'b100 && ir[25:23] == 3'b010) begin
            dec_cls = CLS_ARITH;
        end else if (ir[28:26] == 3'b100 && ir[25:23] == 3'b101) begin
            dec_cls = CLS_MOVE;
        end else if (ir[28:26] == 3'b101) begin
            dec_cls = CLS_BRANCH;
        end else if (ir[27] && !ir[25]) begin
            dec_cls = CLS_MEM;
        end else if (ir[27:25] == 3'b101) begin
            dec_cls = ir[24] ? CLS_ARITH : CLS_LOGIC;
        end
    end

    // Control word of the registered class, and the memory stall condition.
    always_comb begin
        sel_cw = '0;
        case (cls_q)
            CLS_LOGIC:  sel_cw = cw_logic;
            CLS_ARITH:  sel_cw = cw_arith;
            CLS_MOVE:   sel_cw = cw_move;
            CLS_MEM:    sel_cw = cw_mem;
            CLS_BRANCH: sel_cw = cw_branch;
            default:    sel_cw = '0;
        endcase
        stall = (cls_q == CLS_MEM) && !mem_ready;
    end

    // State, IR and class registers; reset aborts any instruction in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm_q <= S_FETCH;
            ir    <= '0;
            cls_q <= CLS_NONE;
        end else begin
            fsm_q <= fsm_d;
            ir    <= ir_d;
            cls_q <= cls_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        fsm_d     = fsm_q;
        ir_d      = ir;
        cls_d     = cls_q;
        fetch_req = 1'b0;
        state     = 1'b0;
        cw_out    = '0;
        illegal   = 1'b0;
        case (fsm_q)
            S_FETCH: begin
                fetch_req = 1'b1;
                if (instr_valid) begin
                    ir_d  = instr_in;
                    fsm_d = S_DECODE;
                end
            end
            S_DECODE: begin
                cls_d = dec_cls;
                if (dec_cls == CLS_ILLEGAL) begin
                    illegal = 1'b1;
`ifdef ILLEGAL_TRAP_EN
                    fsm_d   = S_TRAP;
`else
                    fsm_d   = S_FETCH;
`endif
                end else begin
                    fsm_d = S_EXEC0;
                end
            end
            S_EXEC0: begin
                cw_out = sel_cw;
                if (stall) begin
                    cw_out[RW_BIT] = 1'b0;
                    cw_out[MW_BIT] = 1'b0;
                end else begin
                    fsm_d = sel_cw[NS_BIT] ? S_EXEC1 : S_FETCH;
                end
            end
            S_EXEC1: begin
                state  = 1'b1;
                cw_out = sel_cw;
                if (stall) begin
                    cw_out[RW_BIT] = 1'b0;
                    cw_out[MW_BIT] = 1'b0;
                end else begin
                    fsm_d = S_FETCH;
                end
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: begin
                illegal = 1'b1;
            end
`endif
            default: begin
                fsm_d = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: randomized self-checking bench for control_sequencer.
// Expected behaviour comes from a per-instruction cycle model: the class comes from a
// pattern table, and the bench then walks the expected fetch/decode/execute cycles.
module tb_control_sequencer;

    localparam int unsigned CW_W   = 94;
    localparam int unsigned NS_BIT = 0;
    localparam int unsigned MW_BIT = 1;
    localparam int unsigned RW_BIT = 2;

    localparam logic [31:0] I_ANDI = 32'b1001001000_000000000001_00000_00001;
    localparam logic [31:0] I_ANDR = 32'b10001010000_11111_000000_10000_00100;
    localparam logic [31:0] I_LDUR = 32'hF8400000;
    localparam logic [31:0] I_B    = 32'h14000004;
    localparam logic [31:0] I_ADDI = 32'h91000421;
    localparam logic [31:0] I_MOVZ = 32'hD2800020;

    typedef enum int {C_LOGIC = 0, C_ARITH = 1, C_MOVE = 2, C_MEM = 3, C_BRANCH = 4, C_ILL = 5} cls_e;

    logic            clock = 1'b0;
    logic            reset;
    logic [31:0]     instr_in;
    logic            instr_valid;
    logic            mem_ready;
    logic [CW_W-1:0] cws [5];
    logic            fetch_req;
    logic [31:0]     ir;
    logic            state;
    logic [CW_W-1:0] cw_out;
    logic            illegal;

    int checks = 0;
    int errors = 0;

    control_sequencer #(.CW_W(CW_W), .NS_BIT(NS_BIT), .MW_BIT(MW_BIT), .RW_BIT(RW_BIT)) dut (
        .clock(clock), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
        .mem_ready(mem_ready), .cw_logic(cws[0]), .cw_arith(cws[1]), .cw_move(cws[2]),
        .cw_mem(cws[3]), .cw_branch(cws[4]), .fetch_req(fetch_req), .ir(ir), .state(state),
        .cw_out(cw_out), .illegal(illegal)
    );

    always #5 clock = ~clock;

    // Opcode class from the pattern table over ir[28:23], first row that matches.
    function automatic cls_e model_class(input logic [31:0] w);
        logic [5:0] f;
        f = w[28:23];
        casez (f)
            6'b100100: return C_LOGIC;
            6'b100010: return C_ARITH;
            6'b100101: return C_MOVE;
            6'b101???: return C_BRANCH;
            6'b?1?0??: return C_MEM;
            6'b?1010?: return C_LOGIC;
            6'b?1011?: return C_ARITH;
            default:   return C_ILL;
        endcase
    endfunction

    task automatic rand_cws();
        for (int i = 0; i < 5; i++) cws[i] = CW_W'({$urandom, $urandom, $urandom});
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // One instruction from fetch through retirement, checked every cycle.
    task automatic test_instr(input logic [31:0] instr, input bit ns, input int stall0,
                              input int stall1, input int idle);
        cls_e c;
        logic [CW_W-1:0] exp;
        int nst;
        int stalls;
        c = model_class(instr);
        for (int i = 0; i < idle; i++) begin
            next_cycle();
            instr_valid = 1'b0; instr_in = $urandom; mem_ready = 1'($urandom); rand_cws();
            #2;
            checks++;
            if ({fetch_req, state, illegal} !== 3'b100 || cw_out !== '0) begin
                errors++;
                $display("FAIL fetch_idle: fetch_req/state/illegal=%b%b%b cw_out=%h, expected 100 and 0",
                         fetch_req, state, illegal, cw_out);
            end
        end
        next_cycle();
        instr_valid = 1'b1; instr_in = instr; mem_ready = 1'($urandom); rand_cws();
        #2;
        checks++;
        if ({fetch_req, state, illegal} !== 3'b100 || cw_out !== '0) begin
            errors++;
            $display("FAIL fetch_capture: fetch_req/state/illegal=%b%b%b cw_out=%h, expected 100 and 0",
                     fetch_req, state, illegal, cw_out);
        end
        next_cycle();
        instr_valid = 1'($urandom); instr_in = $urandom; mem_ready = 1'($urandom); rand_cws();
        #2;
        checks++;
        if ({fetch_req, state, illegal} !== {2'b00, c == C_ILL} || cw_out !== '0 || ir !== instr) begin
            errors++;
            $display("FAIL decode: fetch_req/state/illegal=%b%b%b cw_out=%h ir=%h, expected 00%b, 0, ir %h",
                     fetch_req, state, illegal, cw_out, ir, c == C_ILL, instr);
        end
        if (c == C_ILL) return;
        nst = ns ? 2 : 1;
        for (int st = 0; st < nst; st++) begin
            stalls = (c == C_MEM) ? ((st == 0) ? stall0 : stall1) : 0;
            for (int k = 0; k <= stalls; k++) begin
                next_cycle();
                rand_cws();
                if (st == 0) cws[c][NS_BIT] = ns;
                mem_ready = (c == C_MEM) ? (k == stalls) : 1'($urandom);
                instr_valid = 1'($urandom); instr_in = $urandom;
                #2;
                exp = cws[c];
                if (k < stalls) begin
                    exp[RW_BIT] = 1'b0;
                    exp[MW_BIT] = 1'b0;
                end
                checks++;
                if (cw_out !== exp) begin
                    errors++;
                    $display("FAIL exec%0d_cw (stall %0d/%0d): cw_out=%h expected %h", st, k, stalls, cw_out, exp);
                end
                checks++;
                if ({fetch_req, state, illegal} !== {1'b0, 1'(st), 1'b0} || ir !== instr) begin
                    errors++;
                    $display("FAIL exec%0d_flags: fetch_req/state/illegal=%b%b%b ir=%h, expected 0%0d0 ir %h",
                             st, fetch_req, state, illegal, ir, st, instr);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; instr_valid = 1'b0; instr_in = '0; mem_ready = 1'b0; rand_cws();
        #3;
        checks++;
        if ({fetch_req, state, illegal} !== 3'b100 || cw_out !== '0 || ir !== '0) begin
            errors++;
            $display("FAIL reset: fetch_req/state/illegal=%b%b%b cw_out=%h ir=%h, expected 100, 0, 0",
                     fetch_req, state, illegal, cw_out, ir);
        end
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_classes();
        test_instr(I_ANDI, 1'b0, 0, 0, 1);
        test_instr(I_B,    1'b0, 0, 0, 0);
        test_instr(I_ADDI, 1'b0, 0, 0, 2);
        test_instr(I_MOVZ, 1'b0, 0, 0, 0);
    endtask

    task automatic test_two_state();
        test_instr(I_ANDR, 1'b1, 0, 0, 0);
    endtask

    task automatic test_mem_stall();
        test_instr(I_LDUR, 1'b0, 3, 0, 0);
        test_instr(I_LDUR, 1'b1, 1, 2, 0);
    endtask

    task automatic test_reset_mid_exec();
        next_cycle();
        instr_valid = 1'b1; instr_in = I_ANDI; rand_cws();
        next_cycle();
        instr_valid = 1'b0;
        next_cycle();
        rand_cws(); cws[C_LOGIC][NS_BIT] = 1'b0;
        #2;
        checks++;
        if (cw_out !== cws[C_LOGIC] || fetch_req !== 1'b0) begin
            errors++;
            $display("FAIL mid_exec_pre: cw_out=%h fetch_req=%b, expected %h and 0", cw_out, fetch_req, cws[C_LOGIC]);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({fetch_req, state, illegal} !== 3'b100 || cw_out !== '0) begin
            errors++;
            $display("FAIL mid_exec_abort: fetch_req/state/illegal=%b%b%b cw_out=%h, expected 100 and 0",
                     fetch_req, state, illegal, cw_out);
        end
        next_cycle();
        reset = 1'b0;
        #2;
        checks++;
        if (ir !== '0 || fetch_req !== 1'b1) begin
            errors++;
            $display("FAIL mid_exec_release: ir=%h fetch_req=%b, expected 0 and 1", ir, fetch_req);
        end
    endtask

    task automatic test_illegal();
`ifdef ILLEGAL_TRAP_EN
        test_instr(32'h0, 1'b0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            instr_valid = 1'b1; instr_in = I_ANDI; rand_cws();
            #2;
            checks++;
            if ({fetch_req, state, illegal} !== 3'b001 || cw_out !== '0 || ir !== '0) begin
                errors++;
                $display("FAIL trap_hold: fetch_req/state/illegal=%b%b%b cw_out=%h ir=%h, expected 001, 0, 0",
                         fetch_req, state, illegal, cw_out, ir);
            end
        end
        instr_valid = 1'b0;
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        test_instr(I_ANDI, 1'b0, 0, 0, 0);
`else
        test_instr(32'h0, 1'b0, 0, 0, 0);
        test_instr(I_ANDI, 1'b0, 0, 0, 0);
`endif
    endtask

    task automatic test_back_to_back();
        logic [31:0] tbl [6];
        logic [31:0] w;
        tbl = '{I_ANDI, I_ANDR, I_LDUR, I_B, I_ADDI, I_MOVZ};
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(3) == 0) w = $urandom;
            else w = tbl[$urandom_range(5)];
`ifdef ILLEGAL_TRAP_EN
            if (model_class(w) == C_ILL) w = I_B;
`endif
            test_instr(w, 1'($urandom), $urandom_range(3), $urandom_range(2), $urandom_range(1));
        end
        next_cycle();
        instr_valid = 1'b0;
        #2;
        checks++;
        if (fetch_req !== 1'b1 || cw_out !== '0) begin
            errors++;
            $display("FAIL final_fetch: fetch_req=%b cw_out=%h, expected 1 and 0", fetch_req, cw_out);
        end
    endtask

    initial begin
        test_reset();
        test_classes();
        test_two_state();
        test_mem_stall();
        test_reset_mid_exec();
        test_illegal();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
